// File: rtl/mac_acc_sequencer_pkg.sv
// Purpose : shared DLX-extension definitions for the MAC accumulator sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: MAC FSM state encoding, default counter/address widths.
package mac_acc_sequencer_pkg;

    // Default element-counter width; the longest vector is 2^CNT_W-1 pairs.
    localparam int MAC_CNT_W_DEF = 8;
    // Default operand word-address width; addresses wrap modulo 2^AW.
    localparam int MAC_AW_DEF    = 10;

    typedef enum logic [1:0] {
        MAC_S_IDLE  = 2'd0,
        MAC_S_CLEAR = 2'd1,
        MAC_S_FETCH = 2'd2,
        MAC_S_FIN   = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_acc_sequencer_if.sv
// Purpose : bundles the decode-side command, operand-port and accumulator-control signals of the sequencer.
// Latency : n/a (wiring only).
// Backpressure: OP_VALID stalls the fetch; there is no other flow control.
// Ports   : master = EX decode / memory port / accumulator side, slave = the sequencer itself.
interface mac_acc_sequencer_if
    import mac_acc_sequencer_pkg::*;
#(
    parameter int CNT_W = MAC_CNT_W_DEF,
    parameter int AW    = MAC_AW_DEF
) ();

    // command from EX decode
    logic             START;
    logic             ABORT;
    logic [CNT_W-1:0] LEN;
    logic [AW-1:0]    BASE_A;
    logic [AW-1:0]    BASE_B;
    // operand memory port
    logic             OP_REQ;
    logic [AW-1:0]    OP_ADDR_A;
    logic [AW-1:0]    OP_ADDR_B;
    logic             OP_VALID;
    // accumulator register control and status
    logic             ACC_CLR;
    logic             ACC_CE;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] ELEM_CNT;

    modport master (
        output START, ABORT, LEN, BASE_A, BASE_B, OP_VALID,
        input  OP_REQ, OP_ADDR_A, OP_ADDR_B, ACC_CLR, ACC_CE, BUSY, DONE, ELEM_CNT
    );

    modport slave (
        input  START, ABORT, LEN, BASE_A, BASE_B, OP_VALID,
        output OP_REQ, OP_ADDR_A, OP_ADDR_B, ACC_CLR, ACC_CE, BUSY, DONE, ELEM_CNT
    );

endinterface

// File: rtl/mac_acc_sequencer_idx_counter.sv
// Purpose : element index counter with latched length/bases, last-element flag and operand address adders.
// Latency : idx updates one cycle after load/inc; flags and addresses are combinational from registers.
// Backpressure: none; the caller only raises inc on an accepted operand pair.
// Ports   : CLK/RST; load (latch len/bases, clear idx), inc; outputs idx, last, len_zero, addr_a, addr_b.
module mac_idx_counter #(
    parameter int CNT_W = 8,
    parameter int AW    = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] len_in,
    input  logic [AW-1:0]    base_a_in,
    input  logic [AW-1:0]    base_b_in,
    input  logic             inc,
    output logic [CNT_W-1:0] idx,
    output logic             last,
    output logic             len_zero,
    output logic [AW-1:0]    addr_a,
    output logic [AW-1:0]    addr_b
);

    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] len_q;
    logic [AW-1:0]    base_a_q;
    logic [AW-1:0]    base_b_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q    <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
        end else if (load) begin
            idx_q    <= '0;
            len_q    <= len_in;
            base_a_q <= base_a_in;
            base_b_q <= base_b_in;
        end else if (inc) begin
            idx_q <= idx_q + CNT_W'(1);
        end
    end

    assign idx      = idx_q;
    assign len_zero = (len_q == '0);
    // With len_q==0 the comparison wraps to all-ones and never matches idx 0;
    // that case never reaches FETCH anyway.
    assign last     = (idx_q == (len_q - CNT_W'(1)));
    // Sums are truncated to AW bits, so the addresses wrap silently.
    assign addr_a   = base_a_q + AW'(idx_q);
    assign addr_b   = base_b_q + AW'(idx_q);

endmodule

// File: rtl/mac_acc_sequencer.sv
// Purpose : sequences the MAC accumulator: clear on START, then one CE per delivered operand pair, DONE pulse at end.
// Latency : START to DONE = LEN+2 cycles with OP_VALID held high; LEN=0 gives 2 cycles.
// Backpressure: OP_VALID=0 holds FETCH and all outputs indefinitely; START outside IDLE is dropped, not queued.
// Ports   : CLK, RST (sync, active-high); bus = slave side of mac_acc_sequencer_if.
module mac_acc_sequencer
    import mac_acc_sequencer_pkg::*;
#(
    parameter int CNT_W = MAC_CNT_W_DEF,
    parameter int AW    = MAC_AW_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    mac_acc_sequencer_if.slave bus
);

    mac_state_e       state;
    logic             acc_clr_q;
    logic             op_req_q;
    logic             busy_q;
    logic             done_q;

    logic             load;
    logic             acc_ce;
    logic [CNT_W-1:0] idx;
    logic             last;
    logic             len_zero;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;

    assign load   = (state == MAC_S_IDLE) && bus.START;
    // CE follows OP_VALID in the same cycle; ABORT and RST both mask it so
    // a cancelled sequence never adds one more product.
    assign acc_ce = (state == MAC_S_FETCH) && bus.OP_VALID && !bus.ABORT && !RST;

    mac_idx_counter #(
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_idx (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .len_in    (bus.LEN),
        .base_a_in (bus.BASE_A),
        .base_b_in (bus.BASE_B),
        .inc       (acc_ce),
        .idx       (idx),
        .last      (last),
        .len_zero  (len_zero),
        .addr_a    (addr_a),
        .addr_b    (addr_b)
    );

    // Outputs are registered alongside the next state, so each one is a
    // clean decode of the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= MAC_S_IDLE;
            acc_clr_q <= 1'b0;
            op_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                MAC_S_IDLE: begin
                    // ABORT is deliberately not looked at here.
                    if (bus.START) begin
                        state     <= MAC_S_CLEAR;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                MAC_S_CLEAR: begin
                    if (bus.ABORT) begin
                        state  <= MAC_S_IDLE;
                        busy_q <= 1'b0;
                    end else if (len_zero) begin
                        state  <= MAC_S_FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state    <= MAC_S_FETCH;
                        op_req_q <= 1'b1;
                    end
                end
                MAC_S_FETCH: begin
                    if (bus.ABORT) begin
                        state    <= MAC_S_IDLE;
                        op_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (bus.OP_VALID && last) begin
                        state    <= MAC_S_FIN;
                        op_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                MAC_S_FIN: begin
                    state <= MAC_S_IDLE;
                end
                default: begin
                    state <= MAC_S_IDLE;
                end
            endcase
        end
    end

    assign bus.OP_REQ    = op_req_q;
    assign bus.OP_ADDR_A = addr_a;
    assign bus.OP_ADDR_B = addr_b;
    assign bus.ACC_CLR   = acc_clr_q;
    assign bus.ACC_CE    = acc_ce;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ELEM_CNT  = idx;

endmodule

// File: tb/tb_mac_acc_sequencer.sv
// Purpose : self-checking bench for mac_acc_sequencer with a transaction-level reference model.
// Latency : n/a.
// Backpressure: OP_VALID gaps are driven from fixed patterns or $urandom.
module tb_mac_acc_sequencer;

    localparam int CW = 8;
    localparam int AW = 10;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mac_acc_sequencer_if #(.CNT_W(CW), .AW(AW)) bus ();

    mac_acc_sequencer #(.CNT_W(CW), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model of what the idle outputs should show: last latched base plus final count.
    int m_a   = 0;
    int m_b   = 0;
    int m_cnt = 0;

    bit vpat[$];

    logic [32:0] obs;
    logic [32:0] exp_v;

    // {OP_REQ, ACC_CLR, ACC_CE, BUSY, DONE, ADDR_A, ADDR_B, ELEM_CNT}
    function automatic logic [32:0] expect_vec(bit req, bit clr, bit ce, bit busy, bit done,
                                               int a, int b, int cnt);
        logic [9:0] ea;
        logic [9:0] eb;
        logic [7:0] ec;
        ea = 10'(a % 1024);
        eb = 10'(b % 1024);
        ec = 8'(cnt);
        return {req, clr, ce, busy, done, ea, eb, ec};
    endfunction

    function automatic logic [32:0] sample();
        return {bus.OP_REQ, bus.ACC_CLR, bus.ACC_CE, bus.BUSY, bus.DONE,
                bus.OP_ADDR_A, bus.OP_ADDR_B, bus.ELEM_CNT};
    endfunction

    // One full command. vmode: 0 = OP_VALID always 1, 1 = use vpat then 1, 2 = random.
    // abort_at: accept count at which ABORT is raised (with OP_VALID=1), -1 for none.
    // noise: stray START/ABORT/LEN/BASE activity while busy and in FIN.
    task automatic test_sequence(input string name, input int len, input int ba, input int bb,
                                 input int vmode, input int abort_at, input bit noise);
        int  k = 0;
        int  pi = 0;
        int  guard = 0;
        bit  v;
        bit  ab;
        bit  aborted = 0;

        @(negedge CLK);
        bus.START    = 1'b1;
        bus.LEN      = 8'(len);
        bus.BASE_A   = 10'(ba);
        bus.BASE_B   = 10'(bb);
        bus.OP_VALID = 1'($urandom);
        bus.ABORT    = noise;        // ignored in IDLE; START must still win
        #1;
        obs = sample(); exp_v = expect_vec(0, 0, 0, 0, 0, m_a, m_b, m_cnt);
        n_chk++;
        if (obs !== exp_v) $display("FAIL %s/idle_pre: got %h want %h", name, obs, exp_v);
        else n_pass++;

        @(negedge CLK);
        bus.START    = noise ? 1'($urandom) : 1'b0;
        bus.ABORT    = 1'b0;
        bus.OP_VALID = 1'($urandom);
        if (noise) begin
            bus.LEN    = 8'($urandom);
            bus.BASE_A = 10'($urandom);
            bus.BASE_B = 10'($urandom);
        end
        #1;
        obs = sample(); exp_v = expect_vec(0, 1, 0, 1, 0, ba, bb, 0);
        n_chk++;
        if (obs !== exp_v) $display("FAIL %s/clear: got %h want %h", name, obs, exp_v);
        else n_pass++;

        while (!aborted && k < len) begin
            @(negedge CLK);
            guard++;
            if (guard > 4 * len + 50) begin
                n_chk++;
                $display("FAIL %s/fetch_bound: accepts %0d of %0d", name, k, len);
                break;
            end
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (pi < vpat.size()) ? vpat[pi] : 1'b1;
            else                 v = ($urandom_range(0, 2) != 0);
            pi++;
            ab = (k == abort_at);
            if (ab) v = 1'b1;
            bus.OP_VALID = v;
            bus.ABORT    = ab;
            bus.START    = noise ? 1'($urandom) : 1'b0;
            #1;
            obs = sample(); exp_v = expect_vec(1, 0, v && !ab, 1, 0, ba + k, bb + k, k);
            n_chk++;
            if (obs !== exp_v) $display("FAIL %s/fetch k=%0d: got %h want %h", name, k, obs, exp_v);
            else n_pass++;
            if (ab)     aborted = 1'b1;
            else if (v) k++;
        end

        @(negedge CLK);
        bus.ABORT    = noise && !aborted;
        bus.OP_VALID = 1'($urandom);
        bus.START    = noise && !aborted;
        bus.LEN      = 8'($urandom);
        #1;
        obs = sample();
        if (aborted) exp_v = expect_vec(0, 0, 0, 0, 0, ba + k, bb + k, k);
        else         exp_v = expect_vec(0, 0, 0, 0, 1, ba + len, bb + len, len);
        n_chk++;
        if (obs !== exp_v) $display("FAIL %s/%s: got %h want %h", name, aborted ? "abort_idle" : "done", obs, exp_v);
        else n_pass++;

        m_a = (ba + k) % 1024;
        m_b = (bb + k) % 1024;
        m_cnt = k;

        @(negedge CLK);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        #1;
        obs = sample(); exp_v = expect_vec(0, 0, 0, 0, 0, m_a, m_b, m_cnt);
        n_chk++;
        if (obs !== exp_v) $display("FAIL %s/idle_post: got %h want %h", name, obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset();
        RST          = 1'b1;
        bus.START    = 1'b1;
        bus.ABORT    = 1'b0;
        bus.OP_VALID = 1'b1;
        bus.LEN      = 8'd7;
        bus.BASE_A   = 10'h155;
        bus.BASE_B   = 10'h2AA;
        repeat (2) @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            obs = sample(); exp_v = expect_vec(0, 0, 0, 0, 0, 0, 0, 0);
            n_chk++;
            if (obs !== exp_v) $display("FAIL reset/%0d: got %h want %h", i, obs, exp_v);
            else n_pass++;
        end
        @(negedge CLK);
        RST       = 1'b0;
        bus.START = 1'b0;
        m_a = 0; m_b = 0; m_cnt = 0;
    endtask

    task automatic test_basic();
        test_sequence("basic", 4, 'h010, 'h200, 0, -1, 1'b0);
    endtask

    task automatic test_len_bounds();
        test_sequence("len0", 0, 'h123, 'h321, 0, -1, 1'b0);
        test_sequence("len1", 1, 'h040, 'h080, 0, -1, 1'b0);
        test_sequence("len255", 255, 'h300, 'h0F0, 0, -1, 1'b0);
    endtask

    task automatic test_gaps();
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        test_sequence("gaps", 3, 'h0AB, 'h1CD, 1, -1, 1'b0);
    endtask

    task automatic test_wrap();
        test_sequence("wrap", 4, 'h3FE, 'h3FF, 0, -1, 1'b0);
    endtask

    task automatic test_abort();
        test_sequence("abort", 5, 'h011, 'h222, 0, 2, 1'b0);
        test_sequence("after_abort", 3, 'h100, 'h180, 0, -1, 1'b0);
    endtask

    task automatic test_rst_mid();
        @(negedge CLK);
        bus.START = 1'b1; bus.LEN = 8'd6; bus.BASE_A = 10'h050; bus.BASE_B = 10'h060;
        bus.OP_VALID = 1'b1; bus.ABORT = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            bus.START = 1'b0;
        end
        RST = 1'b1;
        #1;
        n_chk++;
        if (bus.ACC_CE !== 1'b0) $display("FAIL rst_mid/ce: got %b want 0", bus.ACC_CE);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        obs = sample(); exp_v = expect_vec(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs !== exp_v) $display("FAIL rst_mid/zero: got %h want %h", obs, exp_v);
        else n_pass++;
        repeat (6) begin
            @(negedge CLK);
            #1;
            obs = sample();
            n_chk++;
            if (obs !== exp_v) $display("FAIL rst_mid/quiet: got %h want %h", obs, exp_v);
            else n_pass++;
        end
        m_a = 0; m_b = 0; m_cnt = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            int len;
            int ab;
            len = $urandom_range(0, 12);
            ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            test_sequence($sformatf("rand%0d", i), len, $urandom_range(0, 1023),
                          $urandom_range(0, 1023), 2, ab, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_bounds();
        test_gaps();
        test_wrap();
        test_abort();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
